// File: rtl/alu_req_arbiter.sv
// Purpose : round-robin share of one ALU between two requesters; latches the winner's operands,
//           waits LAT cycles for the ALU, captures result + flags and returns them with DONE.
// Latency : GNT one cycle after the request edge E0, DONE after E0+LAT+1; one op per LAT+2 cycles.
// Backpress: requesters hold REQ + bundle until GNT; REQ is ignored while an op is in flight (BUSY).
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQ[1:0]                 per-requester pending flag
//   REQ_OPA/OPB/CMD/MODE/CIN/INP_VALID   packed {req1, req0} operand bundles
//   GNT[1:0], DONE[1:0]      one-cycle pulses: bundle sampled / result valid on RSP_*
//   BUSY                     operation in flight
//   RSP_RES, RSP_FLAGS       captured ALU result and {COUT,OFLOW,ERR,E,G,L}
//   ALU_*  (out)             registered operand bundle driven to the ALU
//   ALU_RES, ALU_COUT..ALU_L (in)  ALU outputs
module alu_req_arbiter #(
  parameter int N         = 8,
  parameter int CMD_WIDTH = 4,
  parameter int LAT       = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             REQ,
  input  logic [2*N-1:0]         REQ_OPA,
  input  logic [2*N-1:0]         REQ_OPB,
  input  logic [2*CMD_WIDTH-1:0] REQ_CMD,
  input  logic [1:0]             REQ_MODE,
  input  logic [1:0]             REQ_CIN,
  input  logic [3:0]             REQ_INP_VALID,
  output logic [1:0]             GNT,
  output logic [1:0]             DONE,
  output logic                   BUSY,
  output logic [2*N-1:0]         RSP_RES,
  output logic [5:0]             RSP_FLAGS,
  output logic                   ALU_CE,
  output logic                   ALU_MODE,
  output logic                   ALU_CIN,
  output logic [N-1:0]           ALU_OPA,
  output logic [N-1:0]           ALU_OPB,
  output logic [CMD_WIDTH-1:0]   ALU_CMD,
  output logic [1:0]             ALU_INP_VALID,
  input  logic [2*N-1:0]         ALU_RES,
  input  logic                   ALU_COUT,
  input  logic                   ALU_OFLOW,
  input  logic                   ALU_ERR,
  input  logic                   ALU_E,
  input  logic                   ALU_G,
  input  logic                   ALU_L
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [N-1:0]         opa;
    logic [N-1:0]         opb;
    logic [CMD_WIDTH-1:0] cmd;
    logic                 mode;
    logic                 cin;
    logic [1:0]           iv;
  } bundle_t;

  // Truncated to the 4-bit counter on purpose: with LAT=15 the target is 16, which the
  // counter reaches as 0 after wrapping from 15. The counter is reloaded with 1 on every
  // issue, so 0 can only mean "16 edges since issue".
  localparam logic [3:0] CNT_DONE = 4'(LAT + 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        ptr, ptr_nxt;      // last granted requester
  logic        owner, owner_nxt;  // requester of the op in flight
  logic        win;
  bundle_t     bun0, bun1, bun_q, bun_nxt;
  logic        ce_nxt, busy_nxt;
  logic [1:0]  gnt_nxt, done_nxt;
  logic [2*N-1:0] res_nxt;
  logic [5:0]  flags_nxt;

  assign bun0 = {REQ_OPA[N-1:0], REQ_OPB[N-1:0], REQ_CMD[CMD_WIDTH-1:0],
                 REQ_MODE[0], REQ_CIN[0], REQ_INP_VALID[1:0]};
  assign bun1 = {REQ_OPA[2*N-1:N], REQ_OPB[2*N-1:N], REQ_CMD[2*CMD_WIDTH-1:CMD_WIDTH],
                 REQ_MODE[1], REQ_CIN[1], REQ_INP_VALID[3:2]};

  assign ALU_OPA       = bun_q.opa;
  assign ALU_OPB       = bun_q.opb;
  assign ALU_CMD       = bun_q.cmd;
  assign ALU_MODE      = bun_q.mode;
  assign ALU_CIN       = bun_q.cin;
  assign ALU_INP_VALID = bun_q.iv;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    bun_nxt   = bun_q;
    ce_nxt    = ALU_CE;
    busy_nxt  = BUSY;
    gnt_nxt   = 2'b00;
    done_nxt  = 2'b00;
    res_nxt   = RSP_RES;
    flags_nxt = RSP_FLAGS;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (REQ != 2'b00) begin
          // Under contention the requester that did not win last time goes next.
          win          = (REQ == 2'b11) ? ~ptr : REQ[1];
          bun_nxt      = win ? bun1 : bun0;
          ce_nxt       = 1'b1;
          busy_nxt     = 1'b1;
          gnt_nxt[win] = 1'b1;
          cnt_nxt      = 4'd1;
          ptr_nxt      = win;
          owner_nxt    = win;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == CNT_DONE) begin
          res_nxt          = ALU_RES;
          flags_nxt        = {ALU_COUT, ALU_OFLOW, ALU_ERR, ALU_E, ALU_G, ALU_L};
          done_nxt[owner]  = 1'b1;
          ce_nxt           = 1'b0;
          bun_nxt.iv       = 2'b00;
          busy_nxt         = 1'b0;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ptr       <= 1'b1;
      owner     <= 1'b0;
      bun_q     <= '0;
      ALU_CE    <= 1'b0;
      BUSY      <= 1'b0;
      GNT       <= 2'b00;
      DONE      <= 2'b00;
      RSP_RES   <= '0;
      RSP_FLAGS <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      bun_q     <= bun_nxt;
      ALU_CE    <= ce_nxt;
      BUSY      <= busy_nxt;
      GNT       <= gnt_nxt;
      DONE      <= done_nxt;
      RSP_RES   <= res_nxt;
      RSP_FLAGS <= flags_nxt;
    end
  end

endmodule
